audio_frame_buffer: RTL

- Sits directly downstream of `fir_decimator`.
- Accepts the decimated 8-bit signed audio stream (`filtered_audio` / `data_ready`) and stores it in a circular sample RAM.
- Every HOP new samples, streams out an overlapping analysis frame of FRAME_LEN samples, oldest first, over a valid/ready handshake for the spectral (FFT) stage.
- Input cannot be stalled (the mic path is free-running), so late frame consumption is flagged as overrun.

---
 rtl/audio_pkg.sv | 6 +
 rtl/frame_ram.sv | 23 ++
 rtl/audio_frame_buffer.sv | 92 +++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared sample type, frame FSM states and overrun counter width.
package audio_pkg;
  typedef logic signed [7:0] sample_t;
  typedef enum logic [1:0] {IDLE, READ, STREAM} state_t;
  localparam int OVERRUN_CNT_W = 16;
endpackage

// File: rtl/frame_ram.sv
// frame_ram: simple dual-port sample RAM, sync read, read-before-write.
module frame_ram
  import audio_pkg::*;
#(
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          rst_in_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  sample_t       wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output sample_t       rd_data
);
  sample_t mem [DEPTH];
  always_ff @(posedge clk_in)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/audio_frame_buffer.sv
// audio_frame_buffer: circular sample store emitting overlapping FRAME_LEN frames every HOP samples.
// Define OVERRUN_CNT_EN to add the saturating overrun_count_out port.
module audio_frame_buffer
  import audio_pkg::*;
#(
  parameter int FRAME_LEN = 512,
  parameter int HOP = 256
) (
  input  logic    clk_in,
  input  logic    rst_in_n,
  input  sample_t audio_in,
  input  logic    valid_in,
  output sample_t frame_data_out,
  output logic    frame_valid_out,
  input  logic    frame_ready_in,
  output logic    frame_last_out,
  output logic    overrun_out
`ifdef OVERRUN_CNT_EN
  ,
  output logic [OVERRUN_CNT_W-1:0] overrun_count_out
`endif
);
  localparam int AW = $clog2(FRAME_LEN);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr, rd_addr, pend_addr, beat, start_addr;
  logic [CW-1:0] fill_cnt, hop_cnt;
  logic full, trig, pend, hs;
  state_t state, state_nx;
  assign full = fill_cnt == CW'(FRAME_LEN);
  assign trig = valid_in && (full ? hop_cnt == CW'(HOP - 1) : fill_cnt == CW'(FRAME_LEN - 1));
  assign start_addr = wr_ptr + 1'b1;
  assign frame_valid_out = state == STREAM;
  assign frame_last_out = frame_valid_out && &beat;
  assign hs = frame_valid_out && frame_ready_in;
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      hop_cnt  <= '0;
    end else if (valid_in) begin
      wr_ptr   <= wr_ptr + 1'b1;
      fill_cnt <= full ? fill_cnt : fill_cnt + 1'b1;
      hop_cnt  <= trig ? '0 : hop_cnt + 1'b1;
    end
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? ((trig || pend) ? READ : IDLE) :
               state == READ ? STREAM :
               hs ? (frame_last_out ? IDLE : READ) : STREAM;
  end
  // A fresh trigger in IDLE supersedes any pending start: it is the newer frame.
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) begin
      rd_addr     <= '0;
      beat        <= '0;
      pend        <= 1'b0;
      pend_addr   <= '0;
      overrun_out <= 1'b0;
    end else begin
      overrun_out <= trig && state != IDLE;
      if (state == IDLE && (trig || pend)) begin
        rd_addr <= trig ? start_addr : pend_addr;
        beat    <= '0;
        pend    <= 1'b0;
      end else if (trig) begin
        pend      <= 1'b1;
        pend_addr <= start_addr;
      end
      if (hs && !frame_last_out) begin
        rd_addr <= rd_addr + 1'b1;
        beat    <= beat + 1'b1;
      end
    end
`ifdef OVERRUN_CNT_EN
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) overrun_count_out <= '0;
    else if (overrun_out && !(&overrun_count_out)) overrun_count_out <= overrun_count_out + 1'b1;
`endif
  frame_ram #(.DEPTH(FRAME_LEN)) u_ram (
    .clk_in  (clk_in),
    .rst_in_n(rst_in_n),
    .wr_en   (valid_in),
    .wr_addr (wr_ptr),
    .wr_data (audio_in),
    .rd_en   (state == READ),
    .rd_addr (rd_addr),
    .rd_data (frame_data_out)
  );
endmodule
